// File: rtl/aes_dec_stream_ctrl.sv
// -----------------------------------------------------------------------------
// aes_dec_stream_ctrl
//
// Streaming controller wrapped around an external AES decryption core.
// Ciphertext blocks are buffered in a small FIFO. They are handed to the core
// one at a time, and the core result is post-processed for ECB or CBC before
// it is presented on a valid/ready output stream.
//
// Optional feature: define AES_DEC_STREAM_TIMEOUT_EN to build a WAIT-state
// watchdog. If the core does not finish within TIMEOUT cycles, the block is
// dropped and the sticky err flag is raised. Without the macro, err is tied
// to 0 and WAIT lasts until the core reports done.
//
// Parameters
//   DEPTH    FIFO depth in 128-bit blocks (power of two, 2..16)
//   TIMEOUT  watchdog limit in cycles (8..1023), used only with the macro
//
// Ports
//   clock, reset         single rising-edge clock, async active-high reset
//   key_in               decryption key, forwarded to core_key
//   iv_in, load_iv       CBC initial vector and its load strobe
//   cbc_mode             1 = CBC, 0 = ECB (sampled per block at issue)
//   s_valid/s_ready/s_data   ciphertext input stream
//   m_valid/m_ready/m_data   plaintext output stream
//   core_key, core_din, core_start   request side of the core
//   core_done, core_dout             response side of the core
//   busy                 FSM not idle, or FIFO not empty
//   fifo_count           FIFO occupancy (0..DEPTH)
//   err                  sticky watchdog timeout flag
// -----------------------------------------------------------------------------
module aes_dec_stream_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic [127:0] iv_in,
    input  logic         load_iv,
    input  logic         cbc_mode,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic [127:0] core_key,
    output logic [127:0] core_din,
    output logic         core_start,
    input  logic         core_done,
    input  logic [127:0] core_dout,
    output logic         busy,
    output logic [4:0]   fifo_count,
    output logic         err
);

    localparam int          PTR_W   = $clog2(DEPTH);
    localparam logic [4:0]  DEPTH_C = 5'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;

    logic [127:0]       fifo_mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [4:0]         fifo_count_r;
    logic [4:0]         count_next_s;
    logic               push_s;
    logic               pop_s;

    logic               s_ready_r;
    logic               busy_r;
    logic               m_valid_r;
    logic               core_start_r;

    logic [127:0]       chain_r;
    logic [127:0]       ct_r;
    logic [127:0]       out_r;
    logic               mode_r;

    logic               done_accept_s;
    logic               iv_load_s;
    logic               tmo_hit_s;

    // The key is not registered: the core sees key_in directly.
    assign core_key   = key_in;
    // The head entry is stable through ISSUE, because only ISSUE pops.
    assign core_din   = fifo_mem_r[rd_ptr_r];
    assign s_ready    = s_ready_r;
    assign busy       = busy_r;
    assign m_valid    = m_valid_r;
    assign m_data     = out_r;
    assign core_start = core_start_r;
    assign fifo_count = fifo_count_r;

    assign push_s        = s_valid && s_ready_r;
    assign pop_s         = (state_r == ST_ISSUE);
    assign done_accept_s = (state_r == ST_WAIT) && core_done;
    assign iv_load_s     = load_iv && (state_r == ST_IDLE) && (fifo_count_r == 5'd0);

`ifdef AES_DEC_STREAM_TIMEOUT_EN
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

    logic [9:0] tmo_cnt_r;
    logic       err_r;

    // Timeout fires in the last permitted WAIT cycle if done is still absent.
    assign tmo_hit_s = (state_r == ST_WAIT) && !core_done && (tmo_cnt_r == TMO_LAST);
    assign err       = err_r;

    // Watchdog counter: counts WAIT cycles, cleared outside WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt_r <= 10'd0;
            err_r     <= 1'b0;
        end else if ((state_r == ST_WAIT) && !core_done) begin
            if (tmo_hit_s) begin
                tmo_cnt_r <= 10'd0;
                err_r     <= 1'b1;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + 10'd1;
            end
        end else begin
            tmo_cnt_r <= 10'd0;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
    assign err       = 1'b0;
`endif

    // Next-state logic of the block sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fifo_count_r != 5'd0) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    state_next_s = ST_OUTPUT;
                end else if (tmo_hit_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_OUTPUT: begin
                if (m_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_OUTPUT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FIFO occupancy update; a push and a pop together cancel out.
    always_comb begin
        count_next_s = fifo_count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = fifo_count_r + 5'd1;
            2'b01:   count_next_s = fifo_count_r - 5'd1;
            default: count_next_s = fifo_count_r;
        endcase
    end

    // State, pointers and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_count_r <= 5'd0;
            s_ready_r    <= 1'b1;
            busy_r       <= 1'b0;
            m_valid_r    <= 1'b0;
            core_start_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            fifo_count_r <= count_next_s;
            // Pointers wrap naturally, since DEPTH is a power of two.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            // Status flags are computed from next-cycle values, so they line up with state_r.
            s_ready_r    <= (count_next_s < DEPTH_C);
            busy_r       <= (state_next_s != ST_IDLE) || (count_next_s != 5'd0);
            m_valid_r    <= (state_next_s == ST_OUTPUT);
            core_start_r <= (state_next_s == ST_ISSUE);
        end
    end

    // FIFO storage; contents need no reset because the pointers qualify them.
    always_ff @(posedge clock) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= s_data;
        end
    end

    // Block datapath: ciphertext capture, CBC chaining and output register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain_r <= 128'd0;
            ct_r    <= 128'd0;
            out_r   <= 128'd0;
            mode_r  <= 1'b0;
        end else begin
            if (pop_s) begin
                ct_r   <= fifo_mem_r[rd_ptr_r];
                mode_r <= cbc_mode;
            end
            if (done_accept_s) begin
                // The chain advances in ECB too, but only CBC folds it into the output.
                out_r   <= core_dout ^ (mode_r ? chain_r : 128'd0);
                chain_r <= ct_r;
            end else if (iv_load_s) begin
                chain_r <= iv_in;
            end else begin
                chain_r <= chain_r;
            end
        end
    end

endmodule

// File: tb/tb_aes_dec_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_dec_stream_ctrl
//
// Randomized bench for aes_dec_stream_ctrl. A behavioural core model answers
// each core_start after a random latency. A reference model computes each
// expected plaintext from the accepted ciphertext order and the ECB/CBC
// chaining rule, and an output monitor compares every handshake with it.
// -----------------------------------------------------------------------------
module tb_aes_dec_stream_ctrl;

    localparam int DEPTH = 4;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_IV  = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clock;
    logic         reset;
    logic [127:0] key_in;
    logic [127:0] iv_in;
    logic         load_iv;
    logic         cbc_mode;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic [127:0] core_key;
    logic [127:0] core_din;
    logic         core_start;
    logic         core_done;
    logic [127:0] core_dout;
    logic         busy;
    logic [4:0]   fifo_count;
    logic         err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_starts = 0;

    // Reference model state.
    logic [127:0] exp_q[$];
    logic [127:0] chain_m;

    // Core model and ready-driver controls.
    logic         core_mute;
    logic         inject_done;
    int           fixed_lat;
    logic         hold_rdy;

    aes_dec_stream_ctrl #(.DEPTH(DEPTH), .TIMEOUT(64)) dut (
        .clock      (clock),
        .reset      (reset),
        .key_in     (key_in),
        .iv_in      (iv_in),
        .load_iv    (load_iv),
        .cbc_mode   (cbc_mode),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .core_key   (core_key),
        .core_din   (core_din),
        .core_start (core_start),
        .core_done  (core_done),
        .core_dout  (core_dout),
        .busy       (busy),
        .fifo_count (fifo_count),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural decryption: the FIPS-197 pair, otherwise a keyed bijection.
    function automatic logic [127:0] dec(input logic [127:0] k, input logic [127:0] ct);
        if (k == FIPS_KEY && ct == FIPS_CT) begin
            return FIPS_PT;
        end else begin
            return {ct[63:0], ct[127:64]} ^ k ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
        end
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Offer one block; on acceptance, the model computes its plaintext.
    task automatic send(input logic [127:0] ct, input bit use_model);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = ct;
        while (!s_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (!s_ready) begin
            check("send_accept_timeout", 128'd0, 128'd1);
        end else if (use_model) begin
            exp_q.push_back(dec(key_in, ct) ^ (cbc_mode ? chain_m : 128'd0));
            chain_m = ct;
        end
        @(negedge clock);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clock);
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check("drain_done", 128'((exp_q.size() == 0) && !busy), 128'd1);
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!core_start && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("core_start_seen", 128'(core_start), 128'd1);
    endtask

    // Core model: answers core_start after a latency of 1..4 cycles (or fixed_lat).
    initial begin
        logic [127:0] din_cap;
        bit           pend;
        int           cnt;
        core_done = 1'b0;
        core_dout = 128'd0;
        pend      = 1'b0;
        cnt       = 0;
        din_cap   = 128'd0;
        forever begin
            @(posedge clock);
            #1;
            core_done = 1'b0;
            if (inject_done) begin
                core_done   = 1'b1;
                core_dout   = rnd128();
                inject_done = 1'b0;
            end else if (pend && cnt == 0) begin
                if (!core_mute) begin
                    core_done = 1'b1;
                    core_dout = dec(core_key, din_cap);
                end
                pend = 1'b0;
            end else if (pend) begin
                cnt--;
            end
            if (core_start) begin
                pend    = 1'b1;
                din_cap = core_din;
                cnt     = (fixed_lat > 0) ? fixed_lat - 1 : int'($urandom_range(0, 3));
            end
        end
    end

    // Downstream ready: random, or held low on request.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            m_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Output monitor: ordering, stalled-data stability, and s_ready consistency.
    initial begin
        bit           prev_stall;
        logic [127:0] prev_data;
        logic [127:0] e;
        prev_stall = 1'b0;
        prev_data  = 128'd0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                check("s_ready_vs_count", 128'(s_ready), 128'(fifo_count < 5'd4));
                if (core_start) n_starts++;
                if (prev_stall && m_valid) check("m_data_stable", m_data, prev_data);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", m_data, 128'hx);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", m_data, e);
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        int s0;
        logic [127:0] c1;
        reset       = 1'b1;
        key_in      = FIPS_KEY;
        iv_in       = 128'd0;
        load_iv     = 1'b0;
        cbc_mode    = 1'b0;
        s_valid     = 1'b0;
        s_data      = 128'd0;
        core_mute   = 1'b0;
        inject_done = 1'b0;
        fixed_lat   = 0;
        hold_rdy    = 1'b0;
        chain_m     = 128'd0;

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_m_valid", 128'(m_valid), 128'd0);
        check("rst_s_ready", 128'(s_ready), 128'd1);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_fifo_count", 128'(fifo_count), 128'd0);
        check("rst_err", 128'(err), 128'd0);
        check("rst_core_start", 128'(core_start), 128'd0);
        reset = 1'b0;
        @(negedge clock);
        check("core_key_follow", core_key, FIPS_KEY);

        // ECB FIPS-197 vector with exactly one core_start.
        s0 = n_starts;
        send(FIPS_CT, 1'b1);
        drain();
        @(negedge clock);
        check("fips_one_start", 128'(n_starts - s0), 128'd1);

        // CBC with a loaded IV, two blocks.
        iv_in   = FIPS_IV;
        load_iv = 1'b1;
        @(negedge clock);
        load_iv = 1'b0;
        chain_m = FIPS_IV;
        cbc_mode = 1'b1;
        key_in  = rnd128();
        #1 check("core_key_comb", core_key, key_in);
        c1 = rnd128();
        send(c1, 1'b1);
        send(rnd128(), 1'b1);
        drain();

        // Random streams: ECB, then CBC (the chain carries over from ECB).
        cbc_mode = 1'b0;
        for (int i = 0; i < 12; i++) begin
            send(rnd128(), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        drain();
        cbc_mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(rnd128(), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        drain();

        // Backpressure: m_ready held low while DEPTH+1 blocks are pushed.
        hold_rdy = 1'b1;
        repeat (2) @(negedge clock);
        for (int i = 0; i < DEPTH + 1; i++) send(rnd128(), 1'b1);
        check("bp_fifo_full", 128'(fifo_count), 128'd4);
        check("bp_s_ready_low", 128'(s_ready), 128'd0);
        repeat (20) @(negedge clock);
        check("bp_m_valid_held", 128'(m_valid), 128'd1);
        check("bp_still_full", 128'(fifo_count), 128'd4);
        hold_rdy = 1'b0;
        drain();

        // load_iv pulsed during WAIT must be ignored.
        fixed_lat = 10;
        send(rnd128(), 1'b1);
        wait_start();
        repeat (2) @(negedge clock);
        iv_in   = rnd128();
        load_iv = 1'b1;
        @(negedge clock);
        load_iv = 1'b0;
        drain();
        fixed_lat = 0;
        send(rnd128(), 1'b1);
        drain();

`ifdef AES_DEC_STREAM_TIMEOUT_EN
        // Watchdog: core never answers; both blocks drop, chain unchanged.
        core_mute = 1'b1;
        send(rnd128(), 1'b0);
        wait_start();
        send(rnd128(), 1'b0);
        repeat (63) @(negedge clock);
        check("tmo_err_early", 128'(err), 128'd0);
        @(negedge clock);
        check("tmo_err_set", 128'(err), 128'd1);
        check("tmo_no_valid", 128'(m_valid), 128'd0);
        @(negedge clock);
        check("tmo_next_issued", 128'(core_start), 128'd1);
        repeat (70) @(negedge clock);
        check("tmo_err_sticky", 128'(err), 128'd1);
        check("tmo_idle", 128'(busy), 128'd0);
        core_mute = 1'b0;
        send(rnd128(), 1'b1);
        drain();
`endif

        // Reset mid-WAIT, then a late core_done.
        core_mute = 1'b1;
        fixed_lat = 3;
        send(rnd128(), 1'b0);
        wait_start();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("rst_async_valid", 128'(m_valid), 128'd0);
        check("rst_async_busy", 128'(busy), 128'd0);
        @(negedge clock);
        reset = 1'b0;
        inject_done = 1'b1;
        repeat (5) @(negedge clock);
        check("rst_wait_no_valid", 128'(m_valid), 128'd0);
        check("rst_wait_count", 128'(fifo_count), 128'd0);
        check("rst_wait_err", 128'(err), 128'd0);
        check("rst_wait_busy", 128'(busy), 128'd0);
        core_mute = 1'b0;
        fixed_lat = 0;
        chain_m   = 128'd0;
        cbc_mode  = 1'b1;
        send(rnd128(), 1'b1);
        drain();
        check("final_err", 128'(err), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_dec_stream_ctrl.md
AES_DEC_STREAM_CTRL -- requirements
Module: aes_dec_stream_ctrl

Interface
REQ-001 Parameters SHALL be:
- DEPTH, default 4: input FIFO depth in 128-bit blocks, power of two, 2..16.
- TIMEOUT, default 64: watchdog limit in cycles, 8..1023.
REQ-002 Ports SHALL be as follows. Clock and reset:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
REQ-003 Configuration and upstream ports:
- key_in  in  128  decryption key, passed through to the core.
- iv_in  in  128  CBC initial vector.
- load_iv  in  1  pulse; latch iv_in into the chain register.
- cbc_mode  in  1  1 = CBC, 0 = ECB.
- s_valid  in  1  / s_ready  out  1 / s_data  in  128  ciphertext input stream.
REQ-004 Downstream, core-side and status ports:
- m_valid  out  1 / m_ready  in  1 / m_data  out  128  plaintext output stream.
- core_key  out  128  equals key_in.
- core_din  out  128  ciphertext to the core.
- core_start  out  1  one-cycle start pulse to the core.
- core_done  in  1  core completion.
- core_dout  in  128  raw core output.
- busy  out  1  FSM not in IDLE, or FIFO not empty.
- fifo_count  out  5  FIFO occupancy.
- err  out  1  sticky timeout flag.

Function
REQ-005 The FIFO SHALL accept a block when s_valid and s_ready are both 1; s_ready = (fifo_count < DEPTH).
REQ-006 A push and a pop in the same cycle SHALL leave fifo_count unchanged; a push at full SHALL NOT occur, since s_ready is 0.
REQ-007 Read and write pointers SHALL wrap modulo DEPTH.
REQ-008 The FSM SHALL have the states IDLE, ISSUE, WAIT and OUTPUT.
REQ-009 IDLE SHALL go to ISSUE on the cycle after fifo_count becomes nonzero.
REQ-010 ISSUE SHALL do the following, then go to WAIT:
- pop the FIFO head into ct_reg;
- drive core_din = head;
- assert core_start for exactly one cycle;
- sample cbc_mode into mode_reg.
REQ-011 WAIT SHALL stay in WAIT until core_done = 1. On that edge:
- out_reg = core_dout XOR (mode_reg ? chain : 0);
- chain = ct_reg;
- go to OUTPUT.
REQ-012 OUTPUT SHALL hold m_valid = 1 with m_data = out_reg stable until m_ready = 1, then go to IDLE. Issue-to-output latency SHALL be core latency + 1 cycle.
REQ-013 In ECB mode, chain SHALL still update but SHALL NOT affect m_data.
REQ-014 load_iv SHALL be honoured only in IDLE with fifo_count = 0; otherwise it SHALL be ignored.
REQ-015 core_done outside WAIT SHALL be ignored.
REQ-016 core_key SHALL follow key_in combinationally. key_in changes while busy = 1 are a usage error; the block does not check for them.
REQ-017 The FIFO SHALL keep accepting input during WAIT and OUTPUT.

Reset
REQ-018 Reset assertion SHALL asynchronously force:
- FSM = IDLE;
- FIFO pointers, fifo_count, chain, ct_reg, out_reg and mode_reg = 0;
- m_valid = 0, core_start = 0, err = 0, busy = 0, s_ready = 1.
REQ-019 Reset during WAIT SHALL discard the in-flight block, and a late core_done SHALL be ignored.

Configuration
REQ-020 With AES_DEC_STREAM_TIMEOUT_EN defined, a counter SHALL run in WAIT. If core_done is not seen within TIMEOUT cycles:
- err is set (sticky until reset);
- the block is dropped with no m_valid;
- chain is unchanged;
- the FSM returns to IDLE.
REQ-021 Without AES_DEC_STREAM_TIMEOUT_EN, no counter SHALL be built, err SHALL be tied 0, and WAIT SHALL wait indefinitely.

Verification
REQ-022 ECB, FIPS-197 vector: key 000102030405060708090a0b0c0d0e0f, s_data 69c4e0d86a7b0430d8cdb78070b4c55a -> m_data 00112233445566778899aabbccddeeff, with exactly one core_start pulse.
REQ-023 CBC, iv 000102030405060708090a0b0c0d0e0f loaded, two blocks C1 and C2 -> P1 = D(C1)^iv and P2 = D(C2)^C1; a behavioural core model supplies D.
REQ-024 Backpressure: hold m_ready = 0 for 20 cycles while pushing DEPTH+1 blocks -> s_ready drops at fifo_count = 4, m_data stays stable, and no block is lost or duplicated.
REQ-025 load_iv pulsed during WAIT -> ignored; the next CBC block uses the previous ciphertext as chain.
REQ-026 With the macro defined: core_done never asserted -> err = 1 after 64 WAIT cycles, FSM in IDLE, and the next queued block is issued.
REQ-027 Reset asserted mid-WAIT, then core_done pulsed -> no m_valid, fifo_count = 0, chain = 0.
